// File: rtl/traffic_latency_monitor_pkg.sv
// Shared definitions for the TCDM traffic latency monitor: default widths,
// the ROB ID type, the statistics record and a small popcount helper.
package traffic_latency_monitor_pkg;

  localparam int DefaultMaxOutStandingReads = 1024;
  localparam int DefaultCntWidth            = 32;
  localparam int DefaultLatWidth            = 16;
  localparam int DefaultIdWidth             = $clog2(DefaultMaxOutStandingReads);
  localparam int PopMaxPorts                = 16;
  localparam int PopWidth                   = $clog2(PopMaxPorts) + 1;

  typedef logic [DefaultIdWidth-1:0] rob_id_t;

  typedef struct packed {
    logic [DefaultCntWidth-1:0] num_req;
    logic [DefaultCntWidth-1:0] num_resp;
    logic [DefaultCntWidth-1:0] lat_sum;
    logic [DefaultLatWidth-1:0] lat_min;
    logic [DefaultLatWidth-1:0] lat_max;
  } traffic_stats_t;

  // Number of set bits in a fire vector of up to PopMaxPorts ports.
  function automatic logic [PopWidth-1:0] popcount(input logic [PopMaxPorts-1:0] v);
    logic [PopWidth-1:0] cnt;
    cnt = {PopWidth{1'b0}};
    for (int i = 0; i < PopMaxPorts; i++) begin
      cnt = cnt + {{(PopWidth-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/traffic_latency_monitor_min_max_tree.sv
// Combinational reduction of the per-port matched latencies into the
// cycle's minimum, maximum and sum; ports without a match are ignored.
module traffic_latency_monitor_min_max_tree #(
  parameter int NrTCDM   = 2,
  parameter int LatWidth = 16,
  parameter int CntWidth = 32
) (
  input  logic [NrTCDM-1:0]               i_valid,
  input  logic [NrTCDM-1:0][LatWidth-1:0] i_lat,
  output logic [LatWidth-1:0]             o_min,
  output logic [LatWidth-1:0]             o_max,
  output logic [CntWidth-1:0]             o_sum
);

  // Fold all valid latencies; with no valid port min is all-ones and max is 0.
  always_comb begin
    o_min = {LatWidth{1'b1}};
    o_max = {LatWidth{1'b0}};
    o_sum = {CntWidth{1'b0}};
    for (int i = 0; i < NrTCDM; i++) begin
      if (i_valid[i]) begin
        if (i_lat[i] < o_min) o_min = i_lat[i];
        else                  o_min = o_min;
        if (i_lat[i] > o_max) o_max = i_lat[i];
        else                  o_max = o_max;
        o_sum = o_sum + CntWidth'(i_lat[i]);
      end else begin
        o_sum = o_sum;
      end
    end
  end

endmodule

// File: rtl/traffic_latency_monitor.sv
// Passive TCDM monitor: stamps accepted requests by ROB ID, matches responses,
// accumulates saturating counts and latency statistics, flags ID protocol errors.
module traffic_latency_monitor
  import traffic_latency_monitor_pkg::*;
#(
  parameter int MaxOutStandingReads = DefaultMaxOutStandingReads,
  parameter int NrTCDM              = 2,
  parameter int CntWidth            = DefaultCntWidth,
  parameter int LatWidth            = DefaultLatWidth,
  parameter int IdWidth             = $clog2(MaxOutStandingReads)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             en_i,
  input  logic                             clear_i,
  input  logic [NrTCDM-1:0]                tcdm_req_valid_i,
  input  logic [NrTCDM-1:0]                tcdm_req_ready_i,
  input  logic [NrTCDM-1:0][IdWidth-1:0]   tcdm_req_id_i,
  input  logic [NrTCDM-1:0]                tcdm_resp_valid_i,
  input  logic [NrTCDM-1:0]                tcdm_resp_ready_i,
  input  logic [NrTCDM-1:0][IdWidth-1:0]   tcdm_resp_id_i,
  output logic [CntWidth-1:0]              num_req_o,
  output logic [CntWidth-1:0]              num_resp_o,
  output logic [CntWidth-1:0]              lat_sum_o,
  output logic [LatWidth-1:0]              lat_min_o,
  output logic [LatWidth-1:0]              lat_max_o,
  output logic [IdWidth:0]                 outstanding_o,
  output logic                             err_dup_id_o,
  output logic                             err_unknown_id_o
);

  logic [LatWidth-1:0]            r_now;
  logic [MaxOutStandingReads-1:0] r_pend;
  logic [LatWidth-1:0]            r_stamp [MaxOutStandingReads];
  logic [CntWidth-1:0]            r_num_req, r_num_resp, r_lat_sum;
  logic [LatWidth-1:0]            r_lat_min, r_lat_max;
  logic [IdWidth:0]               r_out;
  logic                           r_err_dup, r_err_unk;

  logic [NrTCDM-1:0]               w_req_fire, w_resp_fire;
  logic [NrTCDM-1:0]               w_resp_hit, w_resp_unk, w_req_new, w_req_dup;
  logic [NrTCDM-1:0]               w_req_busy;
  logic [NrTCDM-1:0][LatWidth-1:0] w_lat;
  logic [LatWidth-1:0]             w_min, w_max;
  logic [CntWidth-1:0]             w_sum;
  logic [CntWidth:0]               w_req_acc, w_resp_acc, w_sum_acc;
  logic                            w_stat_en;

  assign w_req_fire  = tcdm_req_valid_i & tcdm_req_ready_i;
  assign w_resp_fire = tcdm_resp_valid_i & tcdm_resp_ready_i;
  assign w_stat_en   = en_i & ~clear_i;

  // Resolve ports in order, responses first, so that repeated IDs inside one
  // cycle behave exactly like back-to-back single events.
  always_comb begin
    w_resp_hit = {NrTCDM{1'b0}};
    w_req_busy = {NrTCDM{1'b0}};
    w_lat      = '0;
    for (int i = 0; i < NrTCDM; i++) begin
      w_resp_hit[i] = w_resp_fire[i] & r_pend[tcdm_resp_id_i[i]];
      w_lat[i]      = r_now - r_stamp[tcdm_resp_id_i[i]];
      for (int j = 0; j < i; j++) begin
        if (w_resp_fire[j] && (tcdm_resp_id_i[j] == tcdm_resp_id_i[i])) w_resp_hit[i] = 1'b0;
        else                                                            w_resp_hit[i] = w_resp_hit[i];
      end
    end
    for (int i = 0; i < NrTCDM; i++) begin
      w_req_busy[i] = r_pend[tcdm_req_id_i[i]];
      for (int j = 0; j < NrTCDM; j++) begin
        if (w_resp_hit[j] && (tcdm_resp_id_i[j] == tcdm_req_id_i[i])) w_req_busy[i] = 1'b0;
        else                                                          w_req_busy[i] = w_req_busy[i];
      end
      for (int j = 0; j < i; j++) begin
        if (w_req_fire[j] && (tcdm_req_id_i[j] == tcdm_req_id_i[i])) w_req_busy[i] = 1'b1;
        else                                                         w_req_busy[i] = w_req_busy[i];
      end
    end
  end

  assign w_resp_unk = w_resp_fire & ~w_resp_hit;
  assign w_req_new  = w_req_fire & ~w_req_busy;
  assign w_req_dup  = w_req_fire & w_req_busy;

  traffic_latency_monitor_min_max_tree #(
    .NrTCDM  (NrTCDM),
    .LatWidth(LatWidth),
    .CntWidth(CntWidth)
  ) i_tree (
    .i_valid(w_resp_hit),
    .i_lat  (w_lat),
    .o_min  (w_min),
    .o_max  (w_max),
    .o_sum  (w_sum)
  );

  assign w_req_acc  = {1'b0, r_num_req}  + (CntWidth+1)'(popcount(PopMaxPorts'(w_req_fire)));
  assign w_resp_acc = {1'b0, r_num_resp} + (CntWidth+1)'(popcount(PopMaxPorts'(w_resp_hit)));
  assign w_sum_acc  = {1'b0, r_lat_sum}  + {1'b0, w_sum};

  // Free-running timestamp and the pending table; these follow traffic regardless of en_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_now  <= {LatWidth{1'b0}};
      r_pend <= {MaxOutStandingReads{1'b0}};
      r_out  <= {(IdWidth+1){1'b0}};
      for (int k = 0; k < MaxOutStandingReads; k++) r_stamp[k] <= {LatWidth{1'b0}};
    end else begin
      r_now <= r_now + {{(LatWidth-1){1'b0}}, 1'b1};
      r_out <= r_out + (IdWidth+1)'(popcount(PopMaxPorts'(w_req_new)))
                     - (IdWidth+1)'(popcount(PopMaxPorts'(w_resp_hit)));
      for (int i = 0; i < NrTCDM; i++) begin
        if (w_resp_hit[i]) r_pend[tcdm_resp_id_i[i]] <= 1'b0;
      end
      for (int i = 0; i < NrTCDM; i++) begin
        if (w_req_fire[i]) begin
          r_pend[tcdm_req_id_i[i]]  <= 1'b1;
          r_stamp[tcdm_req_id_i[i]] <= r_now;
        end
      end
    end
  end

  // Statistics and sticky errors: clear wins, en_i low freezes, counters saturate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_num_req  <= {CntWidth{1'b0}};
      r_num_resp <= {CntWidth{1'b0}};
      r_lat_sum  <= {CntWidth{1'b0}};
      r_lat_min  <= {LatWidth{1'b1}};
      r_lat_max  <= {LatWidth{1'b0}};
      r_err_dup  <= 1'b0;
      r_err_unk  <= 1'b0;
    end else if (clear_i) begin
      r_num_req  <= {CntWidth{1'b0}};
      r_num_resp <= {CntWidth{1'b0}};
      r_lat_sum  <= {CntWidth{1'b0}};
      r_lat_min  <= {LatWidth{1'b1}};
      r_lat_max  <= {LatWidth{1'b0}};
      r_err_dup  <= 1'b0;
      r_err_unk  <= 1'b0;
    end else if (w_stat_en) begin
      r_num_req  <= w_req_acc[CntWidth]  ? {CntWidth{1'b1}} : w_req_acc[CntWidth-1:0];
      r_num_resp <= w_resp_acc[CntWidth] ? {CntWidth{1'b1}} : w_resp_acc[CntWidth-1:0];
      r_lat_sum  <= w_sum_acc[CntWidth]  ? {CntWidth{1'b1}} : w_sum_acc[CntWidth-1:0];
      if (w_min < r_lat_min) r_lat_min <= w_min;
      if (w_max > r_lat_max) r_lat_max <= w_max;
      r_err_dup  <= r_err_dup | (|w_req_dup);
      r_err_unk  <= r_err_unk | (|w_resp_unk);
    end
  end

  assign num_req_o        = r_num_req;
  assign num_resp_o       = r_num_resp;
  assign lat_sum_o        = r_lat_sum;
  assign lat_min_o        = r_lat_min;
  assign lat_max_o        = r_lat_max;
  assign outstanding_o    = r_out;
  assign err_dup_id_o     = r_err_dup;
  assign err_unknown_id_o = r_err_unk;

endmodule
